// File: rtl/complex_sinusoid_pkg.sv
`default_nettype none
// ============================================================================
// complex_sinusoid_pkg
// Shared CORDIC arctangent table, gain constant and FSM state encoding.
// Revision 1.0 - initial release
// ============================================================================
package complex_sinusoid_pkg;

    localparam int PHASE_WIDTH    = 32;
    localparam int MAX_ITERATIONS = 24;

    // round(atan(2^-i) / (2*pi) * 2^32): micro-rotation angles in turn units
    localparam logic [PHASE_WIDTH-1:0] ATAN_TABLE [0:MAX_ITERATIONS-1] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051
    };

    // Asymptotic CORDIC magnitude gain (~1.6468) in Q16
    localparam int CORDIC_GAIN_Q16 = 107922;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/cordic_vectoring_stage.sv
`default_nettype none
// ============================================================================
// cordic_vectoring_stage
// One combinational vectoring-mode micro-rotation driving y towards zero.
// Revision 1.0 - initial release
// ============================================================================
module cordic_vectoring_stage
    import complex_sinusoid_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic signed [WIDTH-1:0]       i_x,
    input  logic signed [WIDTH-1:0]       i_y,
    input  logic        [PHASE_WIDTH-1:0] i_z,
    input  logic        [4:0]             i_shift,
    input  logic        [PHASE_WIDTH-1:0] i_atan,
    output logic signed [WIDTH-1:0]       o_x,
    output logic signed [WIDTH-1:0]       o_y,
    output logic        [PHASE_WIDTH-1:0] o_z
);

    logic signed [WIDTH-1:0] x_sh;
    logic signed [WIDTH-1:0] y_sh;

    always_comb begin
        x_sh = i_x >>> i_shift;
        y_sh = i_y >>> i_shift;
        if (!i_y[WIDTH-1]) begin
            o_x = i_x + y_sh;
            o_y = i_y - x_sh;
            o_z = i_z + i_atan;
        end else begin
            o_x = i_x - y_sh;
            o_y = i_y + x_sh;
            o_z = i_z - i_atan;
        end
    end

endmodule
`default_nettype wire

// File: rtl/complex_sinusoid_freq_estimator.sv
`default_nettype none
// ============================================================================
// complex_sinusoid_freq_estimator
// Iterative CORDIC phase extraction and averaged phase-step frequency estimate.
// Revision 1.0 - initial release
// ============================================================================
module complex_sinusoid_freq_estimator
    import complex_sinusoid_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ITERATIONS = 16,
    parameter int AVG_LOG2   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [DATA_WIDTH-1:0]   i_real,
    input  logic [DATA_WIDTH-1:0]   i_imag,
    output logic [PHASE_WIDTH-1:0]  o_phase,
    output logic [DATA_WIDTH+1:0]   o_mag,
    output logic                    o_phase_valid,
    output logic [PHASE_WIDTH-1:0]  o_freq_word,
    output logic                    o_freq_valid
);

    localparam int XW = DATA_WIDTH + 2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int AW = PHASE_WIDTH + AVG_LOG2;
    localparam logic [CW-1:0] WINDOW_LEN = CW'(1 << AVG_LOG2);
    localparam logic [4:0]    LAST_ITER  = 5'(ITERATIONS - 1);

    state_e                  state_q, state_d;
    logic [4:0]              iter_q, iter_d;
    logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
    logic [PHASE_WIDTH-1:0]  z_q, z_d;
    logic                    zero_q, zero_d;
    logic                    primed_q, primed_d;
    logic [PHASE_WIDTH-1:0]  prev_phase_q, prev_phase_d;
    logic [AW-1:0]           acc_q, acc_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    ready_q, ready_d;
    logic [PHASE_WIDTH-1:0]  phase_q, phase_d;
    logic [XW-1:0]           mag_q, mag_d;
    logic                    phase_valid_q, phase_valid_d;
    logic [PHASE_WIDTH-1:0]  freq_word_q, freq_word_d;
    logic                    freq_valid_q, freq_valid_d;

    logic signed [XW-1:0]    re_ext, im_ext;
    logic signed [XW-1:0]    x_nxt, y_nxt;
    logic [PHASE_WIDTH-1:0]  z_nxt;
    logic [PHASE_WIDTH-1:0]  diff;
    logic [AW-1:0]           acc_sum;
    logic [CW-1:0]           count_inc;

    cordic_vectoring_stage #(
        .WIDTH (XW)
    ) u_stage (
        .i_x     (x_q),
        .i_y     (y_q),
        .i_z     (z_q),
        .i_shift (iter_q),
        .i_atan  (ATAN_TABLE[iter_q]),
        .o_x     (x_nxt),
        .o_y     (y_nxt),
        .o_z     (z_nxt)
    );

    assign re_ext = {{2{i_real[DATA_WIDTH-1]}}, i_real};
    assign im_ext = {{2{i_imag[DATA_WIDTH-1]}}, i_imag};

    always_comb begin
        state_d       = state_q;
        iter_d        = iter_q;
        x_d           = x_q;
        y_d           = y_q;
        z_d           = z_q;
        zero_d        = zero_q;
        primed_d      = primed_q;
        prev_phase_d  = prev_phase_q;
        acc_d         = acc_q;
        count_d       = count_q;
        ready_d       = ready_q;
        phase_d       = phase_q;
        mag_d         = mag_q;
        phase_valid_d = 1'b0;
        freq_word_d   = freq_word_q;
        freq_valid_d  = 1'b0;
        diff          = '0;
        acc_sum       = '0;
        count_inc     = '0;

        case (state_q)
            IDLE: begin
                if (i_valid && ready_q) begin
                    // Left half-plane: rotate by half a turn so CORDIC converges
                    if (i_real[DATA_WIDTH-1]) begin
                        x_d = -re_ext;
                        y_d = -im_ext;
                        z_d = 32'h8000_0000;
                    end else begin
                        x_d = re_ext;
                        y_d = im_ext;
                        z_d = '0;
                    end
                    zero_d  = (i_real == '0) && (i_imag == '0);
                    iter_d  = '0;
                    ready_d = 1'b0;
                    state_d = ROTATE;
                end
            end
            ROTATE: begin
                x_d    = x_nxt;
                y_d    = y_nxt;
                z_d    = z_nxt;
                iter_d = iter_q + 5'd1;
                if (iter_q == LAST_ITER) begin
                    phase_d       = zero_q ? phase_q : z_nxt;
                    mag_d         = x_nxt;
                    phase_valid_d = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
                // A zero sample has no phase: it neither primes nor moves prev_phase
                if (!primed_q) begin
                    if (!zero_q) begin
                        primed_d     = 1'b1;
                        prev_phase_d = z_q;
                    end
                end else begin
                    diff      = zero_q ? '0 : (z_q - prev_phase_q);
                    acc_sum   = acc_q + {{AVG_LOG2{diff[PHASE_WIDTH-1]}}, diff};
                    count_inc = count_q + CW'(1);
                    if (!zero_q) begin
                        prev_phase_d = z_q;
                    end
                    if (count_inc == WINDOW_LEN) begin
                        freq_word_d  = acc_sum[AW-1:AVG_LOG2];
                        freq_valid_d = 1'b1;
                        acc_d        = '0;
                        count_d      = '0;
                    end else begin
                        acc_d   = acc_sum;
                        count_d = count_inc;
                    end
                end
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            iter_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            z_q           <= '0;
            zero_q        <= 1'b0;
            primed_q      <= 1'b0;
            prev_phase_q  <= '0;
            acc_q         <= '0;
            count_q       <= '0;
            ready_q       <= 1'b1;
            phase_q       <= '0;
            mag_q         <= '0;
            phase_valid_q <= 1'b0;
            freq_word_q   <= '0;
            freq_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            iter_q        <= iter_d;
            x_q           <= x_d;
            y_q           <= y_d;
            z_q           <= z_d;
            zero_q        <= zero_d;
            primed_q      <= primed_d;
            prev_phase_q  <= prev_phase_d;
            acc_q         <= acc_d;
            count_q       <= count_d;
            ready_q       <= ready_d;
            phase_q       <= phase_d;
            mag_q         <= mag_d;
            phase_valid_q <= phase_valid_d;
            freq_word_q   <= freq_word_d;
            freq_valid_q  <= freq_valid_d;
        end
    end

    assign o_ready       = ready_q;
    assign o_phase       = phase_q;
    assign o_mag         = mag_q;
    assign o_phase_valid = phase_valid_q;
    assign o_freq_word   = freq_word_q;
    assign o_freq_valid  = freq_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_complex_sinusoid_freq_estimator.sv
`default_nettype none
// ============================================================================
// tb_complex_sinusoid_freq_estimator
// Directed quadrant, tone-loopback, backpressure, reset and zero-sample checks.
// Revision 1.0 - initial release
// ============================================================================
module tb_complex_sinusoid_freq_estimator;

    localparam int DW   = 16;
    localparam int ITER = 16;
    localparam int AVG  = 4;

    logic                 i_clk   = 1'b0;
    logic                 i_rst   = 1'b1;
    logic                 i_valid = 1'b0;
    logic signed [DW-1:0] i_real  = '0;
    logic signed [DW-1:0] i_imag  = '0;
    logic                 o_ready;
    logic [31:0]          o_phase;
    logic [DW+1:0]        o_mag;
    logic                 o_phase_valid;
    logic [31:0]          o_freq_word;
    logic                 o_freq_valid;

    complex_sinusoid_freq_estimator #(
        .DATA_WIDTH (DW),
        .ITERATIONS (ITER),
        .AVG_LOG2   (AVG)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_real        (i_real),
        .i_imag        (i_imag),
        .o_phase       (o_phase),
        .o_mag         (o_mag),
        .o_phase_valid (o_phase_valid),
        .o_freq_word   (o_freq_word),
        .o_freq_valid  (o_freq_valid)
    );

    always #5 i_clk = ~i_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;
    int          prev_acc = 0;
    int          n_acc    = 0;
    int          n_phase  = 0;
    int          n_freq   = 0;
    bit          pending  = 1'b0;
    bit          have_prev = 1'b0;
    bit          bp_mode  = 1'b0;
    logic [31:0] last_phase = '0;
    logic [31:0] last_mag   = '0;
    logic [31:0] last_freq  = '0;

    // Wrap-aware comparison: |obs - exp| taken as a 32-bit signed distance
    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp, input int unsigned tol);
        logic signed [31:0] d;
        d = obs - exp;
        if (d < 0) d = -d;
        n_checks++;
        if ($unsigned(d) > tol) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (tol 0x%0h)", tag, obs, exp, tol);
        end
    endtask

    // Handshake and output monitor, one process so no variable has two writers
    always begin
        @(posedge i_clk);
        if (i_rst) begin
            pending   = 1'b0;
            have_prev = 1'b0;
        end else if (i_valid && o_ready) begin
            if (bp_mode && have_prev) check_val("bp_spacing", 32'(cyc - prev_acc), 32'(ITER + 2), 0);
            prev_acc  = cyc;
            have_prev = 1'b1;
            acc_cyc   = cyc;
            pending   = 1'b1;
            n_acc++;
        end
        cyc++;
        @(negedge i_clk);
        if (o_phase_valid) begin
            check_val("pv_latency", 32'(cyc), pending ? 32'(acc_cyc + ITER + 1) : 32'hFFFF_FFFF, 0);
            pending    = 1'b0;
            n_phase++;
            last_phase = o_phase;
            last_mag   = 32'(o_mag);
        end
        if (o_freq_valid) begin
            n_freq++;
            last_freq = o_freq_word;
        end
    end

    function automatic void tone(input logic [31:0] ph,
                                 output logic signed [DW-1:0] re,
                                 output logic signed [DW-1:0] im);
        real a;
        a  = 6.283185307179586 * real'(ph) / 4294967296.0;
        re = DW'($rtoi(16000.0 * $cos(a)));
        im = DW'($rtoi(16000.0 * $sin(a)));
    endfunction

    task automatic reset_dut();
        i_valid = 1'b0;
        i_rst   = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        #1;
    endtask

    task automatic push(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
        int n;
        n       = 0;
        i_real  = re;
        i_imag  = im;
        i_valid = 1'b1;
        while (!o_ready && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 100) check_val("push_timeout", 32'(n), 32'd0, 0);
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_phase();
        int start;
        int n;
        start = n_phase;
        n     = 0;
        while (n_phase == start && n < 60) begin
            @(negedge i_clk);
            #1;
            n++;
        end
        if (n_phase == start) check_val("phase_timeout", 32'(n), 32'd0, 0);
    endtask

    // Streams a tone of step freq; sample index zero_idx (if >= 0) is (0,0) and does not advance phase
    task automatic run_tone(input logic [31:0] freq, input int nsamp, input int zero_idx,
                            input logic [31:0] exp_freq, input bit do_rst, input string tag);
        logic [31:0]          p;
        logic signed [DW-1:0] re, im;
        logic [31:0]          saved;
        int                   nf0;
        int                   nf;
        if (do_rst) reset_dut();
        p   = '0;
        nf0 = n_freq;
        for (int j = 0; j < nsamp; j++) begin
            nf = n_freq;
            if (j == zero_idx) begin
                saved = last_phase;
                push('0, '0);
                wait_phase();
                check_val({tag, "_zero_mag"}, last_mag, 32'd0, 0);
                check_val({tag, "_zero_phase"}, last_phase, saved, 0);
            end else begin
                tone(p, re, im);
                push(re, im);
                wait_phase();
                p = p + freq;
            end
            @(negedge i_clk);
            #1;
            if (j == 15) check_val({tag, "_no_freq_at16"}, 32'(n_freq - nf0), 32'd0, 0);
            if (j == 16) check_val({tag, "_freq_at17"}, 32'(n_freq - nf0), 32'd1, 0);
            if (n_freq != nf) check_val({tag, "_freq"}, last_freq, exp_freq, 32'h2000);
        end
    endtask

    logic signed [DW-1:0] q_re  [4] = '{16'sd16384, 16'sd0, -16'sd16384, 16'sd0};
    logic signed [DW-1:0] q_im  [4] = '{16'sd0, 16'sd16384, 16'sd0, -16'sd16384};
    logic [31:0]          q_ph  [4] = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};

    initial begin
        int a0;
        reset_dut();
        check_val("rst_ready", 32'(o_ready), 32'd1, 0);
        check_val("rst_phase", o_phase, 32'd0, 0);
        check_val("rst_mag", 32'(o_mag), 32'd0, 0);
        check_val("rst_pvalid", 32'(o_phase_valid), 32'd0, 0);
        check_val("rst_freq", o_freq_word, 32'd0, 0);
        check_val("rst_fvalid", 32'(o_freq_valid), 32'd0, 0);

        for (int q = 0; q < 4; q++) begin
            push(q_re[q], q_im[q]);
            wait_phase();
            check_val($sformatf("quad%0d_phase", q), last_phase, q_ph[q], 32'h10000);
            check_val($sformatf("quad%0d_mag", q), last_mag, 32'd26981, 4);
            @(negedge i_clk);
            #1;
        end

        run_tone(32'h0100_0000, 33, -1, 32'h0100_0000, 1'b1, "pos");
        run_tone(32'hFF00_0000, 17, -1, 32'hFF00_0000, 1'b1, "neg");

        reset_dut();
        bp_mode = 1'b1;
        a0      = n_acc;
        i_valid = 1'b1;
        repeat (60) begin
            i_real = DW'($urandom_range(1, 30000));
            i_imag = DW'($urandom_range(0, 30000));
            @(negedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        repeat (20) @(negedge i_clk);
        #1;
        bp_mode = 1'b0;
        check_val("bp_accepts", 32'(n_acc - a0), 32'd4, 0);

        // Abort a sample mid-rotation; the tone loop below then checks re-priming
        push(16'sd16384, 16'sd0);
        repeat (5) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check_val("abort_ready", 32'(o_ready), 32'd1, 0);
        check_val("abort_phase", o_phase, 32'd0, 0);
        check_val("abort_mag", 32'(o_mag), 32'd0, 0);
        check_val("abort_freq", o_freq_word, 32'd0, 0);
        check_val("abort_fvalid", 32'(o_freq_valid), 32'd0, 0);
        run_tone(32'h0100_0000, 17, -1, 32'h0100_0000, 1'b0, "abort");

        run_tone(32'h0100_0000, 17, 5, 32'h00F0_0000, 1'b1, "zero");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
